// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default constants
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 868;
    localparam int UART_DATA_WIDTH   = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with clear and terminal-count tick
module uart_baud_tick #(
    parameter int  CLKS_PER_BIT = 868,
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    // Count 0..CLKS_PER_BIT-1 and wrap, so consecutive bits need no restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - FIFO-fed UART transmitter; UART_TX_PARITY_EN adds a parity bit
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk_tx,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_bad_params
        $error("uart_tx_ctrl: illegal CLKS_PER_BIT, STOP_BITS or PARITY_ODD");
    end

    uart_state_t           state;
    uart_state_t           next_state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      bit_idx_d;
    logic                  stop_idx;
    logic                  stop_idx_d;
    logic                  baud_clear;
    logic [CNT_W-1:0]      baud_count;
    logic                  baud_tick;
    logic                  tx_d;
    logic                  rd_en_d;
    logic                  busy_d;
    logic                  done_d;

    // The bit timer only runs while a frame is on the line.
    assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk_tx),
        .rst   (rst),
        .clear (baud_clear),
        .count (baud_count),
        .tick  (baud_tick)
    );

    // State, bit indices and the byte latched from the FIFO read port.
    always_ff @(posedge clk_tx or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
        end else begin
            state    <= next_state;
            bit_idx  <= bit_idx_d;
            stop_idx <= stop_idx_d;
            if (state == LOAD) begin
                shift_reg <= fifo_data;
            end
        end
    end

    // Frame sequencing; fifo_empty is only looked at from IDLE.
    always_comb begin
        next_state = state;
        bit_idx_d  = bit_idx;
        stop_idx_d = stop_idx;
        case (state)
            IDLE:  if (!fifo_empty) next_state = FETCH;
            FETCH: next_state = LOAD;
            LOAD:  next_state = START;
            START: if (baud_tick) next_state = DATA;
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_tick) next_state = STOP;
`endif
            STOP: begin
                if (baud_tick) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        stop_idx_d = 1'b0;
                        next_state = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered copies line up with it.
    always_comb begin
        tx_d    = 1'b1;
        rd_en_d = (next_state == FETCH);
        busy_d  = (next_state != IDLE);
        done_d  = (state == STOP) && (stop_idx == 1'(STOP_BITS - 1)) &&
                  (baud_count == CNT_W'(CLKS_PER_BIT - 2));
        case (next_state)
            START: tx_d = 1'b0;
            DATA:  tx_d = shift_reg[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = (^shift_reg) ^ 1'(PARITY_ODD);
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // Output registers; reset forces the line high immediately.
    always_ff @(posedge clk_tx or posedge rst) begin
        if (rst) begin
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx         <= tx_d;
            fifo_rd_en <= rd_en_d;
            busy       <= busy_d;
            tx_done    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic       fifo2_empty = 1'b1;
    logic [7:0] fifo2_data = 8'h00;
    logic       fifo2_rd_en;
    logic       tx2;
    logic       busy2;
    logic       tx_done2;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    logic [7:0] q[$];

    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk_tx(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
        .clk_tx(clk), .rst(rst), .fifo_empty(fifo2_empty), .fifo_data(fifo2_data),
        .fifo_rd_en(fifo2_rd_en), .tx(tx2), .busy(busy2), .tx_done(tx_done2)
    );

    always #5 clk = ~clk;

    // Registered-read FIFO model for the first instance.
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (q.size() > 0) fifo_data = q.pop_front();
        end
        if (tx_done) done_cnt = done_cnt + 1;
        fifo_empty = (q.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(posedge clk);
        #1;
        q.push_back(b);
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int c);
        int slot;
        slot = (c - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (PAR_EN == 1 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic sel_tx(input int d);
        return (d == 2) ? tx2 : tx;
    endfunction

    task automatic wait_start(input int d, input string tag);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (sel_tx(d) == 1'b0) break;
        end
        check({tag, "_start"}, 32'(sel_tx(d)), 32'd0);
    endtask

    // Entered at the negedge of the first start-bit cycle; leaves at the last stop cycle.
    task automatic check_frame(input int d, input logic [7:0] b, input int stops, input string tag);
        int len;
        len = (1 + 8 + PAR_EN + stops) * CPB;
        for (int c = 1; c <= len; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("%s_tx_c%0d", tag, c), 32'(sel_tx(d)), 32'(exp_tx(b, c)));
            check($sformatf("%s_done_c%0d", tag, c),
                  32'((d == 2) ? tx_done2 : tx_done), 32'(c == len));
            check($sformatf("%s_busy_c%0d", tag, c), 32'((d == 2) ? busy2 : busy), 32'd1);
        end
    endtask

    initial begin
        int gap;
        int rd0;
        int done0;

        // 1: reset and idle with an empty FIFO
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t1_rst_%0d", i), 32'({tx, fifo_rd_en, busy, tx_done}), 32'b1000);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("t1_idle_%0d", i), 32'({tx, fifo_rd_en, busy, tx_done}), 32'b1000);
        end

        // 2: single byte 0xA5
        rd0 = rd_cnt;
        push(8'hA5);
        @(negedge clk);
        @(negedge clk);
        check("t2_rd_en_fetch", 32'(fifo_rd_en), 32'd1);
        check("t2_busy_fetch", 32'(busy), 32'd1);
        @(negedge clk);
        check("t2_rd_en_load", 32'(fifo_rd_en), 32'd0);
        check("t2_tx_load", 32'(tx), 32'd1);
        @(negedge clk);
        check_frame(1, 8'hA5, 1, "t2");
        @(negedge clk);
        check("t2_idle_after", 32'({tx, busy, tx_done}), 32'b100);
        check("t2_rd_pulses", 32'(rd_cnt - rd0), 32'd1);

        // 3: back-to-back 0x00 then 0xFF
        repeat (3) @(negedge clk);
        rd0 = rd_cnt;
        push(8'h00);
        push(8'hFF);
        wait_start(1, "t3a");
        check_frame(1, 8'h00, 1, "t3a");
        gap = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx == 1'b0) break;
            gap++;
        end
        check("t3_gap", 32'(gap), 32'd3);
        check_frame(1, 8'hFF, 1, "t3b");
        @(negedge clk);
        check("t3_rd_pulses", 32'(rd_cnt - rd0), 32'd2);

        // 4: reset during data bit 3 of 0x5A
        repeat (3) @(negedge clk);
        push(8'h5A);
        wait_start(1, "t4");
        repeat (17) @(negedge clk);
        check("t4_bit3", 32'(tx), 32'd1);
        done0 = done_cnt;
        rst = 1'b1;
        #1;
        check("t4_rst_tx", 32'(tx), 32'd1);
        check("t4_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("t4_idle_%0d", i), 32'({tx, fifo_rd_en, busy, tx_done}), 32'b1000);
        end
        check("t4_no_done", 32'(done_cnt - done0), 32'd0);

        // 5: parity bytes 0x07 and 0x03
        push(8'h07);
        wait_start(1, "t5a");
        check_frame(1, 8'h07, 1, "t5a");
        push(8'h03);
        wait_start(1, "t5b");
        check_frame(1, 8'h03, 1, "t5b");

        // 6: two stop bits, byte 0x81
        fifo2_data = 8'h81;
        fifo2_empty = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fifo2_rd_en) break;
        end
        check("t6_rd_en", 32'(fifo2_rd_en), 32'd1);
        fifo2_empty = 1'b1;
        wait_start(2, "t6");
        check_frame(2, 8'h81, 2, "t6");
        @(negedge clk);
        check("t6_idle_after", 32'({tx2, busy2, tx_done2}), 32'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
